// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request/response handshake,
// the byte-wide program-load port and the sticky halt flag.
interface imem_responder_if #(
  parameter int unsigned AW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [63:0]   rsp_addr;
  logic [1:0]    rsp_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_byte;
  logic          halt_seen;

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_byte,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, halt_seen
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_byte,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, halt_seen
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed wait, little-endian
// 32-bit word or error code back; byte write port for program loading.
module imem_responder #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  imem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
  localparam logic [63:0]   MAX_ADDR = 64'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [7:0] r_mem [DEPTH_BYTES];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_req_addr;
  logic          r_req_ready;
  logic          w_req_ready_nxt;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic [63:0]   r_rsp_addr;
  logic [1:0]    r_rsp_err;
  logic          r_halt;

  logic          w_accept;
  logic          w_retire;
  logic          w_load;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_err;
  logic [31:0]   w_word;

  assign w_accept = bus.req_valid && r_req_ready && (r_state == S_IDLE);
  assign w_retire = r_rsp_valid && bus.rsp_ready;
  // First RESP cycle captures the word; array writes on this same edge land afterwards.
  assign w_load   = (r_state == S_RESP) && !r_rsp_valid;

  assign w_idx    = r_req_addr[AW-1:0];
  assign w_err[0] = |r_req_addr[1:0];
  assign w_err[1] = r_req_addr > MAX_ADDR;
  assign w_word   = (w_err != 2'b00) ? 32'd0 :
                    {r_mem[w_idx + AW'(3)], r_mem[w_idx + AW'(2)],
                     r_mem[w_idx + AW'(1)], r_mem[w_idx]};

  // Program-load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_byte;
  end

  // Next-state and registered-output intent.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (w_retire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_addr  <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= '0;
      r_halt      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      if (w_accept) begin
        r_req_addr <= bus.req_addr;
        r_cnt      <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_word;
        r_rsp_addr  <= r_req_addr;
        r_rsp_err   <= w_err;
      end else if (w_retire) begin
        r_rsp_valid <= 1'b0;
      end
      // HALT is recognised only when the word is actually consumed by fetch.
      if (w_retire && (r_rsp_err == 2'b00) && (r_rsp_data[31:21] == 11'h7FF)) r_halt <= 1'b1;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.halt_seen = r_halt;
endmodule
